// File: rtl/sdram_port_arbiter.sv
// Two-port arbiter sharing the SDRAM controller master port, with in-order read-response routing.
// Optional build macro SDRAM_ARB_ROUND_ROBIN_EN: round-robin on contention instead of fixed port-0 priority.
module sdram_port_arbiter #(
  parameter int ADDR_W    = 22,
  parameter int DATA_W    = 16,
  parameter int TAG_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     p0_addr,
  input  logic [DATA_W-1:0]     p0_wdata,
  input  logic [DATA_W/8-1:0]   p0_be,
  input  logic                  p0_rd,
  input  logic                  p0_wr,
  output logic                  p0_wait,
  output logic [DATA_W-1:0]     p0_rdata,
  output logic                  p0_rvalid,
  input  logic [ADDR_W-1:0]     p1_addr,
  input  logic [DATA_W-1:0]     p1_wdata,
  input  logic [DATA_W/8-1:0]   p1_be,
  input  logic                  p1_rd,
  input  logic                  p1_wr,
  output logic                  p1_wait,
  output logic [DATA_W-1:0]     p1_rdata,
  output logic                  p1_rvalid,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_be_n,
  output logic                  m_cs,
  output logic                  m_rd_n,
  output logic                  m_wr_n,
  input  logic                  m_waitrequest,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic                  m_rvalid,
  output logic                  rsp_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]        state;
  logic              lock_port;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  logic              last_grant;
`endif

  logic              req0, req1, rd0, rd1;
  logic              elig0, elig1;
  logic              tag_full, tag_empty;
  logic              grant_port, present, accepted;
  logic              sel_rd, sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [BE_W-1:0]   sel_be;
  logic              push, pop, pop_id;

  logic              tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  tag_count;

  // A write wins over a read when both strobes are high; reads are held off while the tag FIFO is full.
  assign req0      = p0_rd | p0_wr;
  assign req1      = p1_rd | p1_wr;
  assign rd0       = p0_rd & ~p0_wr;
  assign rd1       = p1_rd & ~p1_wr;
  assign tag_full  = (tag_count == CNT_W'(TAG_DEPTH));
  assign tag_empty = (tag_count == '0);
  assign elig0     = req0 & ~(rd0 & tag_full);
  assign elig1     = req1 & ~(rd1 & tag_full);

  always_comb begin
    grant_port = 1'b0;
    present    = 1'b0;
    if (reset) begin
      present = 1'b0;
    end else if (state == ST_LOCKED) begin
      grant_port = lock_port;
      present    = lock_port ? elig1 : elig0;
    end else if (elig0 && elig1) begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      grant_port = ~last_grant;
`else
      grant_port = 1'b0;
`endif
      present    = 1'b1;
    end else if (elig0) begin
      grant_port = 1'b0;
      present    = 1'b1;
    end else if (elig1) begin
      grant_port = 1'b1;
      present    = 1'b1;
    end
  end

  assign sel_rd    = grant_port ? rd1 : rd0;
  assign sel_wr    = grant_port ? p1_wr : p0_wr;
  assign sel_addr  = grant_port ? p1_addr : p0_addr;
  assign sel_wdata = grant_port ? p1_wdata : p0_wdata;
  assign sel_be    = grant_port ? p1_be : p0_be;

  assign m_cs      = present;
  assign m_rd_n    = ~(present & sel_rd);
  assign m_wr_n    = ~(present & sel_wr);
  assign m_addr    = present ? sel_addr : '0;
  assign m_wdata   = present ? sel_wdata : '0;
  assign m_be_n    = present ? ~sel_be : '1;

  assign accepted  = present & ~m_waitrequest;
  assign p0_wait   = ~(accepted & ~grant_port);
  assign p1_wait   = ~(accepted & grant_port);

  assign push      = accepted & sel_rd;
  assign pop       = m_rvalid & ~tag_empty;
  assign pop_id    = tag_mem[rd_ptr];

  // A stalled command pins the grant; leaving LOCKED happens on acceptance or if the request vanishes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      lock_port <= 1'b0;
    end else if (present && m_waitrequest) begin
      state     <= ST_LOCKED;
      lock_port <= grant_port;
    end else begin
      state     <= ST_IDLE;
    end
  end

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (accepted) begin
      last_grant <= grant_port;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tag_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   tag_count <= tag_count + CNT_W'(1);
        2'b01:   tag_count <= tag_count - CNT_W'(1);
        default: tag_count <= tag_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr] <= grant_port;
    end
  end

  // Read data is routed to the port recorded at the head of the tag FIFO; orphan responses are flagged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      p0_rvalid <= pop & ~pop_id;
      p1_rvalid <= pop & pop_id;
      if (pop && !pop_id) begin
        p0_rdata <= m_rdata;
      end
      if (pop && pop_id) begin
        p1_rdata <= m_rdata;
      end
      if (m_rvalid && tag_empty) begin
        rsp_err <= 1'b1;
      end
    end
  end

endmodule
